wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Shares one Wishbone peripheral port between pCtrls controller ports, one transaction at a time, with round-robin fairness.
- Sits between the controllers (UART bridge, SPI bridge, debug engine) and the peripheral interconnect or a single peripheral.
- Exposes grant and busy status, sized to drive the LED debug display directly.

Parameters:
- pCtrls, 2, number of controller ports (2..8).
- pTimeout, 255, watchdog limit in cycles; used only with WB_ARBITER_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  reset, synchronous, active-low (rst=0 resets).
- ctrl_c  in  iWishbone_Ctrl[pCtrls]  requests from controllers (stb, we, adr, dat).
- ctrl_p  out  iWishbone_Peri[pCtrls]  responses to controllers (ack, dat).
- wb_c  out  iWishbone_Ctrl  request to the shared peripheral side.
- wb_p  in  iWishbone_Peri  response from the shared peripheral side.
- grant  out  $clog2(pCtrls)  index of the current or last owner.
- busy  out  1  high while a transaction is owned.

Behaviour:
- FSM with two states:
  - IDLE: no owner. wb_c is all zero. Every ctrl_p is all zero.
  - BUSY: owner = grant. wb_c = ctrl_c[grant] (combinational mux). ctrl_p[grant] = wb_p. All other ctrl_p are zero.
- IDLE -> BUSY: when any ctrl_c[i].stb=1. Winner is the first requester, searching upward from (last+1) mod pCtrls with wrap-around. Grant is registered: a request seen in cycle N drives wb_c.stb in cycle N+1.
- BUSY -> IDLE on any of these:
  - wb_p.ack=1: forwarded to the owner in the same cycle; last <= grant.
  - Owner drops stb (abort): no ack is produced; last <= grant.
  - Watchdog fires (optional feature).
- Minimum turnaround is 1 idle cycle between transactions. Back-to-back requests from one controller therefore take at least 3 cycles each when the peripheral acks in 1 cycle.
- Non-owners holding stb wait with ack=0. They are never dropped and never reordered among themselves.
- Simultaneous ack and a new request: ack completes, FSM goes to IDLE, and the new request is arbitrated in the following cycle with the just-served port at lowest priority.
- ack arriving in IDLE is ignored and not forwarded.
- Reset values: state=IDLE, last=pCtrls-1 (port 0 has first priority), grant=0, busy=0. With these, wb_c=0 and all ctrl_p=0.
- Reset mid-transaction: on the next edge the FSM returns to IDLE and wb_c.stb drops. A late ack from the peripheral is discarded.
- ctrl_p[*].dat is zero except on the owner's port during BUSY, so or-reduction debug taps stay clean.

Optional Feature:
- Macro: WB_ARBITER_TIMEOUT_EN.
- With the macro: an 8..16-bit counter clears on entering BUSY and increments each BUSY cycle without ack. If it reaches pTimeout, the arbiter:
  - presents ctrl_p[grant].ack=1 with dat=0 for one cycle,
  - deasserts wb_c.stb,
  - goes to IDLE, sets last <= grant, and pulses a 1-cycle internal timeout flag (mapped to busy's LED in top-level builds).
- A real ack in the same cycle as the timeout takes precedence and passes real data.
- Without the macro: no counter. BUSY waits indefinitely for ack or abort.

Decomposition:
- Shared Wishbone package holds:
  - iWishbone_Ctrl and iWishbone_Peri typedefs (already used codebase-wide),
  - width constants for adr/dat,
  - a default pTimeout constant.
- One sub-module, rr_picker: purely combinational.
  - Inputs: request vector, last index.
  - Outputs: valid, winner index.
  - Instantiated once and reusable by future schedulers.

Test Plan:
- Reset, then ctrl_c[0] write stb with adr=0x04, dat=0xA5; peripheral acks 2 cycles after seeing stb -> wb_c.stb rises 1 cycle after request; wb_c.adr=0x04, dat=0xA5; ctrl_p[0].ack for exactly 1 cycle; busy falls the next cycle.
- Both controllers assert stb at once after reset -> port 0 is served first, then port 1; grant shows 0 then 1; ctrl_p[1].ack=0 during port 0's transaction.
- Port 0 re-requests immediately after its ack while port 1 waits -> port 1 is granted next (fairness); 3 ports all requesting continuously -> grant order 0,1,2,0,1,2.
- Read from port 1 where the peripheral returns dat=0x3C with ack -> ctrl_p[1].dat=0x3C in the ack cycle; ctrl_p[0].dat=0 throughout.
- Owner drops stb mid-BUSY, or rst=0 asserted mid-BUSY -> wb_c.stb=0 on the next edge; no ack to any port; a late wb_p.ack is ignored.
- With WB_ARBITER_TIMEOUT_EN and pTimeout=8, peripheral never acks -> owner receives ack with dat=0 on the 8th BUSY cycle; the next requester is granted afterwards. Without the macro, the bench sees a stall past 100 cycles.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone types and constants for the controller-side arbiter and its helpers.
package wb_arbiter_pkg;

  localparam int unsigned WbAdrW           = 16;
  localparam int unsigned WbDatW           = 8;
  localparam int unsigned WbTimeoutDefault = 255;

  typedef struct packed {
    logic              stb;
    logic              we;
    logic [WbAdrW-1:0] adr;
    logic [WbDatW-1:0] dat;
  } iWishbone_Ctrl;

  typedef struct packed {
    logic              ack;
    logic [WbDatW-1:0] dat;
  } iWishbone_Peri;

  // Watchdog counter width: wide enough for the limit, clamped to 8..16 bits.
  function automatic int unsigned wdog_width(int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from last+1, wrapping.
module wb_arbiter_rr_picker
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] last,
  output logic            valid,
  output logic [IdxW-1:0] winner
);

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    for (int k = N; k >= 1; k--) begin
      if (req[IdxW'((int'(last) + k) % int'(N))]) begin
        valid  = 1'b1;
        winner = IdxW'((int'(last) + k) % int'(N));
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone peripheral port among pCtrls controllers.
// Optional watchdog enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned pCtrls   = 2,
  parameter int unsigned pTimeout = WbTimeoutDefault
) (
  input  logic                      clk,
  input  logic                      rst,
  input  iWishbone_Ctrl             ctrl_c [pCtrls],
  output iWishbone_Peri             ctrl_p [pCtrls],
  output iWishbone_Ctrl             wb_c,
  input  iWishbone_Peri             wb_p,
  output logic [$clog2(pCtrls)-1:0] grant,
  output logic                      busy
);

  localparam int unsigned IdxW = $clog2(pCtrls);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   grant_q;
  logic [IdxW-1:0]   last_q;
  logic              busy_q;
  logic [pCtrls-1:0] req;
  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic              timeout_hit;
  logic              timeout_q;

  always_comb begin
    for (int i = 0; i < pCtrls; i++) req[i] = ctrl_c[i].stb;
  end

  wb_arbiter_rr_picker #(
    .N    (pCtrls),
    .IdxW (IdxW)
  ) u_picker (
    .req    (req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int unsigned     CntW    = wdog_width(pTimeout);
  localparam logic [CntW-1:0] CntLast = CntW'(pTimeout - 1);

  logic [CntW-1:0] cnt_q;

  // Fires on the pTimeout-th BUSY cycle; a real ack in that cycle wins.
  assign timeout_hit = (state_q == StBusy) && !wb_p.ack && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state_q != StBusy) begin
        cnt_q <= '0;
      end else if (!wb_p.ack) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^pTimeout;
  assign timeout_hit    = 1'b0;
  assign timeout_q      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      last_q  <= IdxW'(pCtrls - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q <= StBusy;
            grant_q <= pick_idx;
            busy_q  <= 1'b1;
          end
        end
        StBusy: begin
          // Ack, owner abort and watchdog all end the transaction the same way.
          if (wb_p.ack || !ctrl_c[grant_q].stb || timeout_hit) begin
            state_q <= StIdle;
            last_q  <= grant_q;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Only the owner sees the peripheral; everything else stays zero for clean debug taps.
  always_comb begin
    wb_c = '0;
    for (int i = 0; i < pCtrls; i++) ctrl_p[i] = '0;
    if (state_q == StBusy) begin
      wb_c            = ctrl_c[grant_q];
      ctrl_p[grant_q] = wb_p;
      if (timeout_hit) begin
        wb_c.stb        = 1'b0;
        ctrl_p[grant_q] = '{ack: 1'b1, dat: '0};
      end
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q | timeout_q;

endmodule
